// File: rtl/if_fetch_queue.sv
// Show-ahead instruction fetch queue between the IF and ID stages, flushed on a taken branch.
// Define IFQ_BYPASS_EN to let an instruction pass straight through an empty queue when it is pushed and popped in the same cycle.
module if_fetch_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    flush_i,
  input  logic                    push_i,
  input  logic [WIDTH-1:0]        pc_i,
  input  logic [WIDTH-1:0]        instr_i,
  output logic                    full_o,
  input  logic                    pop_i,
  output logic                    valid_o,
  output logic [WIDTH-1:0]        pc_o,
  output logic [WIDTH-1:0]        pc_plus4_o,
  output logic [WIDTH-1:0]        instr_o,
  output logic [$clog2(DEPTH):0]  count_o
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] pc_mem    [DEPTH];
  logic [WIDTH-1:0] instr_mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;

  logic stored, bypass, pop_eff, push_acc;

  always_comb begin
    stored = (count != '0);
`ifdef IFQ_BYPASS_EN
    bypass = !stored && push_i && pop_i && !flush_i;
`else
    bypass = 1'b0;
`endif
    pop_eff  = pop_i && stored;
    // A bypassed instruction is consumed directly, so it must not also be stored.
    push_acc = push_i && !bypass && ((count != FULL_CNT) || pop_eff);
  end

  always_comb begin
    pc_o    = '0;
    instr_o = '0;
    if (stored) begin
      pc_o    = pc_mem[rd_ptr];
      instr_o = instr_mem[rd_ptr];
    end else if (bypass) begin
      pc_o    = pc_i;
      instr_o = instr_i;
    end
    valid_o    = stored || bypass;
    pc_plus4_o = pc_o + WIDTH'(4);
    full_o     = (count == FULL_CNT);
    count_o    = count;
  end

  always_ff @(posedge clk_i) begin
    if (push_acc) begin
      pc_mem[wr_ptr]    <= pc_i;
      instr_mem[wr_ptr] <= instr_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_acc) wr_ptr <= wr_ptr + AW'(1);
      if (pop_eff)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_acc, pop_eff})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Scoreboard bench for if_fetch_queue: directed scenarios then random traffic against a queue-based reference model.
module tb_if_fetch_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned WIDTH = 32;

  logic              clk = 1'b0;
  logic              rst, flush, push, pop;
  logic [WIDTH-1:0]  pc_in, instr_in;
  logic              full, valid;
  logic [WIDTH-1:0]  pc_out, pc4_out, instr_out;
  logic [$clog2(DEPTH):0] count;

  if_fetch_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .push_i(push),
    .pc_i(pc_in), .instr_i(instr_in), .full_o(full), .pop_i(pop),
    .valid_o(valid), .pc_o(pc_out), .pc_plus4_o(pc4_out),
    .instr_o(instr_out), .count_o(count)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
  typedef struct {
    logic        valid;
    logic        full;
    logic [31:0] count;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
  } exp_t;

  ent_t model[$];
  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s at %0t: got %h required %h", name, $time, act, req);
    end
  endtask

  // Monitor: compares whatever the DUT presents mid-cycle against the oldest expectation.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("valid", 32'(valid), 32'(e.valid));
      chk("full", 32'(full), 32'(e.full));
      chk("count", 32'(count), e.count);
      chk("pc", pc_out, e.pc);
      chk("pc_plus4", pc4_out, e.pc4);
      chk("instr", instr_out, e.instr);
    end
  end

  // One clock of stimulus: drive inputs, predict outputs, then advance the model to the next edge.
  task automatic cycle(input logic r, input logic f, input logic pu, input logic po,
                       input logic [31:0] p, input logic [31:0] ins);
    exp_t e;
    logic empty, byp, pop_eff, push_acc;
    @(posedge clk);
    #1;
    rst = r; flush = f; push = pu; pop = po; pc_in = p; instr_in = ins;
    empty = (model.size() == 0);
`ifdef IFQ_BYPASS_EN
    byp = empty && pu && po && !f;
`else
    byp = 1'b0;
`endif
    e.valid = !empty || byp;
    e.count = model.size();
    e.full  = (model.size() == DEPTH);
    if (!empty) begin
      e.pc = model[0].pc; e.instr = model[0].instr;
    end else if (byp) begin
      e.pc = p; e.instr = ins;
    end else begin
      e.pc = 32'h0; e.instr = 32'h0;
    end
    e.pc4 = e.valid ? e.pc + 32'd4 : 32'd4;
    exp_q.push_back(e);

    pop_eff  = po && !empty;
    push_acc = pu && !byp && (model.size() < DEPTH || pop_eff);
    if (r || f) begin
      model.delete();
    end else begin
      if (pop_eff)  void'(model.pop_front());
      if (push_acc) model.push_back('{pc: p, instr: ins});
    end
  endtask

  task automatic idle();
    cycle(0, 0, 0, 0, 32'h0, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; push = 1'b0; pop = 1'b0; pc_in = '0; instr_in = '0;
    @(posedge clk);
    // Reset with a simultaneous push: nothing may be stored.
    cycle(1, 0, 1, 0, 32'h100, 32'hDEAD);
    idle();
    // Fill to full, dropped fifth push, then drain in order plus one empty pop.
    for (int i = 0; i < 4; i++) cycle(0, 0, 1, 0, 32'(4*i), 32'(32'hA0 + i));
    cycle(0, 0, 1, 0, 32'h10, 32'hA4);
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 1, 32'h0, 32'h0);
    // Push and pop while full.
    for (int i = 0; i < 4; i++) cycle(0, 0, 1, 0, 32'(4*i), 32'(32'hB0 + i));
    cycle(0, 0, 1, 1, 32'h10, 32'hB4);
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 1, 32'h0, 32'h0);
    // Flush overrides same-cycle push and pop.
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0, 32'(32'h200 + 4*i), 32'(32'hC0 + i));
    cycle(0, 1, 1, 1, 32'h300, 32'hCC);
    idle();
    // Steady-state count of 2 across pointer wrap, including the top-of-address-space PC.
    cycle(0, 0, 1, 0, 32'hFFFF_FFF4, 32'hD0);
    cycle(0, 0, 1, 0, 32'hFFFF_FFF8, 32'hD1);
    cycle(0, 0, 1, 1, 32'hFFFF_FFFC, 32'hD2);
    for (int i = 0; i < 9; i++) cycle(0, 0, 1, 1, 32'(4*i), 32'(32'hD3 + i));
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, 32'h0, 32'h0);
    // Push and pop into an empty queue.
    cycle(0, 0, 1, 1, 32'h40, 32'h1234);
    idle();
    cycle(0, 0, 0, 1, 32'h0, 32'h0);
    // Reset mid-stream; the next push becomes the head.
    cycle(0, 0, 1, 0, 32'h500, 32'hE0);
    cycle(0, 0, 1, 0, 32'h504, 32'hE1);
    cycle(1, 0, 1, 1, 32'h508, 32'hE2);
    cycle(0, 0, 1, 0, 32'h600, 32'hE3);
    cycle(0, 0, 0, 1, 32'h0, 32'h0);
    idle();
    // Random traffic.
    for (int i = 0; i < 500; i++) begin
      logic [31:0] p;
      p = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
      cycle($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 5,
            $urandom_range(0, 99) < 65, $urandom_range(0, 99) < 50,
            p, $urandom());
    end
    idle();
    for (int i = 0; i < 4 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending expectations required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/if_fetch_queue.md
IF_FETCH_QUEUE -- requirements
Module: if_fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of queue entries (power of two, >= 2).
REQ-002 SHALL have parameter WIDTH, default 32, width of PC and instruction words.
REQ-003 SHALL have port clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port flush_i  input  1  discard all queued instructions (branch/jump taken).
REQ-006 SHALL have port push_i  input  1  IF stage presents a fetched instruction this cycle.
REQ-007 SHALL have port pc_i  input  WIDTH  address of the pushed instruction (PC register output).
REQ-008 SHALL have port instr_i  input  WIDTH  pushed instruction word from instruction memory.
REQ-009 SHALL have port full_o  output  1  count == DEPTH; IF uses ~full_o to gate the PC write enable.
REQ-010 SHALL have port pop_i  input  1  ID stage consumes the head entry this cycle (ID not stalled).
REQ-011 SHALL have port valid_o  output  1  head entry present on pc_o/instr_o.
REQ-012 SHALL have port pc_o  output  WIDTH  PC of the head instruction.
REQ-013 SHALL have port pc_plus4_o  output  WIDTH  pc_o + 4.
REQ-014 SHALL have port instr_o  output  WIDTH  head instruction word.
REQ-015 SHALL have port count_o  output  log2(DEPTH)+1  number of stored entries.

Function
REQ-016 SHALL operate as a show-ahead FIFO: head entry visible on outputs combinationally from storage, no read latency.
REQ-017 Push SHALL be accepted when push_i=1 and (count < DEPTH or an effective pop occurs the same cycle).
REQ-018 Push when full without pop SHALL be dropped with no change to storage, count or pointers.
REQ-019 Pop SHALL be effective only when pop_i=1 and valid_o=1; pop when empty SHALL be ignored.
REQ-020 Simultaneous accepted push and effective pop SHALL leave count unchanged and advance both pointers.
REQ-021 Read/write pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH or go below 0.
REQ-022 flush_i=1 SHALL set count and both pointers to 0 on the next edge, overriding push and pop in the same cycle.
REQ-023 When valid_o=0, pc_o and instr_o SHALL be 0 (instr_o = MIPS NOP) and pc_plus4_o SHALL be 4.
REQ-024 pc_plus4_o SHALL be computed mod 2^WIDTH (0xFFFFFFFC -> 0x00000000).
REQ-025 full_o SHALL be combinational from count only, not from push_i/pop_i.

Reset
REQ-026 rst_i=1 at a rising edge SHALL clear count and pointers to 0, making valid_o=0, full_o=0, count_o=0, pc_o=0, instr_o=0.
REQ-027 rst_i SHALL have priority over flush_i, push_i and pop_i; storage array contents need not be cleared.
REQ-028 Reset asserted mid-stream SHALL discard all entries; the first push after deassertion SHALL be the new head.

Configuration
REQ-029 Macro IFQ_BYPASS_EN defined: when count=0, push_i=1, pop_i=1 and flush_i=0, valid_o SHALL be 1 that cycle with outputs driven from pc_i/instr_i, and the entry SHALL NOT be stored (count stays 0).
REQ-030 IFQ_BYPASS_EN undefined: valid_o SHALL derive from stored entries only; minimum push-to-visible latency is one cycle, and push+pop when empty stores the entry (count becomes 1).

Verification
REQ-031 Reset: rst_i=1 one cycle with push_i=1 -> count_o=0, valid_o=0, instr_o=0, pc_plus4_o=4.
REQ-032 Fill: push pc 0x0,0x4,0x8,0xC (instr 0xA0..0xA3), pop_i=0 -> full_o=1 after 4th edge; 5th push (pc 0x10) dropped; pops then return 0x0..0xC in order, pc_plus4_o 0x4..0x10.
REQ-033 Full push+pop: at count=4 push pc 0x10 with pop_i=1 -> count stays 4, head becomes 0x4, 0x10 returned last.
REQ-034 Flush: count=3, same cycle flush_i=1, push_i=1, pop_i=1 -> next cycle count_o=0, valid_o=0.
REQ-035 Wrap: 10 push/pop cycles at steady count=2 -> order preserved across pointer wrap; pc 0xFFFFFFFC gives pc_plus4_o=0x0.
REQ-036 Bypass: empty queue, push pc 0x40 instr 0x1234 with pop_i=1 -> with IFQ_BYPASS_EN valid_o=1, pc_o=0x40 same cycle, count_o=0 next; without it valid_o=0 that cycle, count_o=1 next.
